// File: rtl/adc_pkg.sv
// Shared types and default timing for the ADC sample filter.
// Defaults assume a 24 MHz system clock, a 1.2 MHz ADC sclk and 100 kS/s sampling.
package adc_pkg;

  localparam int unsigned ADC_WIDTH      = 12;

  localparam int unsigned CLK_HZ         = 24_000_000;
  localparam int unsigned ADC_SCLK_HZ    = 1_200_000;
  localparam int unsigned SAMPLE_RATE_HZ = 100_000;

  localparam int unsigned DEF_SAMPLE_PERIOD = CLK_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned DEF_READ_HOLD     = CLK_HZ / ADC_SCLK_HZ;
  localparam int unsigned DEF_CONV_CYCLES   = 200;
  localparam int unsigned DEF_CAL_CYCLES    = 700;
  localparam int unsigned DEF_AVG_LOG2      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CONV,
    ST_CAPTURE,
    ST_GAP,
    ST_RECAL,
    ST_CALWAIT
  } adc_state_e;

endpackage

// File: rtl/adc_avg_acc.sv
// Block averager: accumulates 2^AVG_LOG2 samples, publishes the truncated mean
// and latches a sticky fault when a new mean falls outside the thresholds.
module adc_avg_acc
  import adc_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 capture,
  input  logic                 fault_clear,
  input  logic [ADC_WIDTH-1:0] sample,
  input  logic [ADC_WIDTH-1:0] thr_high,
  input  logic [ADC_WIDTH-1:0] thr_low,
  output logic [ADC_WIDTH-1:0] avg_value,
  output logic                 avg_valid,
  output logic                 fault
);

  localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned BLOCK = 1 << AVG_LOG2;

  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc_sum_c;
  logic [ADC_WIDTH-1:0] avg_new_c;
  logic                 block_done_c;
  logic                 out_of_range_c;

  // Running sum including the sample being captured this cycle.
  always_comb begin
    acc_sum_c      = acc + ACC_W'(sample);
    avg_new_c      = ADC_WIDTH'(acc_sum_c >> AVG_LOG2);
    block_done_c   = capture && !clear && (cnt == CNT_W'(BLOCK - 1));
    out_of_range_c = (avg_new_c > thr_high) || (avg_new_c < thr_low);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      avg_value <= '0;
      avg_valid <= 1'b0;
      fault     <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (block_done_c) begin
        acc       <= '0;
        cnt       <= '0;
        avg_value <= avg_new_c;
        avg_valid <= 1'b1;
      end else if (capture) begin
        acc <= acc_sum_c;
        cnt <= cnt + CNT_W'(1);
      end
      // A new violation outranks a coincident clear.
      if (block_done_c && out_of_range_c) begin
        fault <= 1'b1;
      end else if (fault_clear) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_sample_filter.sv
// Paces ADC conversions at a fixed period, feeds captured results to the block
// averager, and slots recalibration requests between conversions.
module adc_sample_filter
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned READ_HOLD     = DEF_READ_HOLD,
  parameter int unsigned CONV_CYCLES   = DEF_CONV_CYCLES,
  parameter int unsigned CAL_CYCLES    = DEF_CAL_CYCLES,
  parameter int unsigned AVG_LOG2      = DEF_AVG_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 recal_req,
  input  logic                 fault_clear,
  input  logic [ADC_WIDTH-1:0] thr_high,
  input  logic [ADC_WIDTH-1:0] thr_low,
  input  logic [ADC_WIDTH-1:0] adc_value,
  output logic                 adc_read,
  output logic                 adc_recalibrate,
  output logic [ADC_WIDTH-1:0] avg_value,
  output logic                 avg_valid,
  output logic                 fault,
  output logic                 busy
);

  localparam int unsigned HOLD_CONV_MAX = (READ_HOLD > CONV_CYCLES) ? READ_HOLD : CONV_CYCLES;
  localparam int unsigned TMR_MAX       = (HOLD_CONV_MAX > CAL_CYCLES) ? HOLD_CONV_MAX : CAL_CYCLES;
  localparam int unsigned TMR_W         = $clog2(TMR_MAX + 1);
  localparam int unsigned PER_W         = $clog2(SAMPLE_PERIOD + 1);

  adc_state_e       state;
  logic [TMR_W-1:0] tmr;
  logic [PER_W-1:0] per_cnt;
  logic             recal_pending;
  logic             clear_c;
  logic             capture_c;

  // Partial blocks are dropped whenever sampling pauses or the ADC recalibrates.
  always_comb begin
    clear_c   = (state == ST_IDLE) || (state == ST_RECAL);
    capture_c = (state == ST_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      tmr             <= '0;
      per_cnt         <= '0;
      recal_pending   <= 1'b0;
      adc_read        <= 1'b0;
      adc_recalibrate <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // per_cnt counts cycles since the last read start and parks at the period end.
      if (per_cnt != PER_W'(SAMPLE_PERIOD - 1)) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      tmr <= tmr + TMR_W'(1);

      case (state)
        ST_IDLE: begin
          tmr  <= '0;
          busy <= 1'b0;
          if (recal_pending) begin
            state           <= ST_RECAL;
            adc_recalibrate <= 1'b1;
            recal_pending   <= 1'b0;
            busy            <= 1'b1;
          end else if (enable) begin
            state    <= ST_READ;
            adc_read <= 1'b1;
            per_cnt  <= '0;
            busy     <= 1'b1;
          end
        end
        ST_READ: begin
          if (tmr == TMR_W'(READ_HOLD - 1)) begin
            state    <= ST_CONV;
            adc_read <= 1'b0;
            tmr      <= '0;
          end
        end
        ST_CONV: begin
          if (tmr == TMR_W'(CONV_CYCLES - 1)) begin
            state <= ST_CAPTURE;
            tmr   <= '0;
          end
        end
        ST_CAPTURE: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            tmr <= '0;
            if (recal_pending) begin
              state           <= ST_RECAL;
              adc_recalibrate <= 1'b1;
              recal_pending   <= 1'b0;
            end else if (enable) begin
              state    <= ST_READ;
              adc_read <= 1'b1;
              per_cnt  <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_RECAL: begin
          if (tmr == TMR_W'(READ_HOLD - 1)) begin
            state           <= ST_CALWAIT;
            adc_recalibrate <= 1'b0;
            tmr             <= '0;
          end
        end
        ST_CALWAIT: begin
          if (tmr == TMR_W'(CAL_CYCLES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            tmr   <= '0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          adc_read        <= 1'b0;
          adc_recalibrate <= 1'b0;
          busy            <= 1'b0;
        end
      endcase

      // Requests arriving at any time (including during RECAL entry) are remembered.
      if (recal_req) begin
        recal_pending <= 1'b1;
      end
    end
  end

  adc_avg_acc #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_c),
    .capture    (capture_c),
    .fault_clear(fault_clear),
    .sample     (adc_value),
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .avg_value  (avg_value),
    .avg_valid  (avg_valid),
    .fault      (fault)
  );

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed + randomized bench for adc_sample_filter with an ADC behavioural model
// and an arithmetic reference for block averages and the sticky fault.
module tb_adc_sample_filter;

  localparam int unsigned SP   = 40;
  localparam int unsigned RH   = 4;
  localparam int unsigned CONV = 10;
  localparam int unsigned CAL  = 8;
  localparam int unsigned AL   = 2;

  logic        clk = 1'b0;
  logic        reset, enable, recal_req, fault_clear;
  logic [11:0] thr_high, thr_low, adc_value, avg_value;
  logic        adc_read, adc_recalibrate, avg_valid, fault, busy;

  int checks = 0, failures = 0, cyc = 0;
  int read_cnt = 0, last_read = 0, prev_read = 0;
  int recal_cnt = 0, last_recal = 0;
  logic read_q = 1'b0, recal_q = 1'b0;
  logic [11:0] adc_q[$];

  adc_sample_filter #(
    .SAMPLE_PERIOD(SP), .READ_HOLD(RH), .CONV_CYCLES(CONV),
    .CAL_CYCLES(CAL), .AVG_LOG2(AL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .recal_req(recal_req),
    .fault_clear(fault_clear), .thr_high(thr_high), .thr_low(thr_low),
    .adc_value(adc_value), .adc_read(adc_read), .adc_recalibrate(adc_recalibrate),
    .avg_value(avg_value), .avg_valid(avg_valid), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge monitor: cycle numbers of read and recalibration starts.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (adc_read && !read_q) begin
      read_cnt++;
      prev_read = last_read;
      last_read = cyc;
    end
    if (adc_recalibrate && !recal_q) begin
      recal_cnt++;
      last_recal = cyc;
    end
    read_q  = adc_read;
    recal_q = adc_recalibrate;
  end

  // ADC model: junk during conversion, queued result valid CONV cycles after read ends.
  initial begin
    adc_value = '0;
    forever begin
      @(posedge adc_read);
      adc_value = 12'($urandom);
      @(negedge adc_read);
      repeat (CONV) @(posedge clk);
      #1;
      adc_value = (adc_q.size() > 0) ? adc_q.pop_front() : 12'd0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_avg(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = avg_valid;
    end
    check({tag, "_avg_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_reads(input int target, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (read_cnt >= target);
    end
    check({tag, "_read_seen"}, 32'(got), 32'd1);
  endtask

  task automatic push4(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    adc_q.push_back(a); adc_q.push_back(b); adc_q.push_back(c); adc_q.push_back(d);
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_adc_read"}, 32'(adc_read), 32'd0);
    check({tag, "_adc_recal"}, 32'(adc_recalibrate), 32'd0);
    check({tag, "_avg_value"}, 32'(avg_value), 32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [11:0] v[4];
    int r0, hi, exp_avg, tl, th, t_idle;
    bit exp_fault, got;

    reset = 1'b1; enable = 1'b0; recal_req = 1'b0; fault_clear = 1'b0;
    thr_high = 12'd4095; thr_low = 12'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic average and read pacing.
    push4(12'd100, 12'd200, 12'd300, 12'd400);
    enable = 1'b1;
    wait_avg("t1");
    check("t1_avg", 32'(avg_value), 32'd250);
    check("t1_fault", 32'(fault), 32'd0);
    check("t1_reads", 32'(read_cnt), 32'd4);
    check("t1_spacing", 32'(last_read - prev_read), 32'(SP));
    check("t1_latency", 32'(cyc - last_read), 32'(RH + CONV + 1));
    push4(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    thr_high = 12'd4000;
    @(negedge clk);
    check("t1_strobe_len", 32'(avg_valid), 32'd0);

    // High threshold, stickiness, clear, and set-beats-clear.
    wait_avg("t2a");
    check("t2a_avg", 32'(avg_value), 32'd4095);
    check("t2a_fault", 32'(fault), 32'd1);
    push4(12'd1000, 12'd1000, 12'd1000, 12'd1000);
    wait_avg("t2b");
    check("t2b_avg", 32'(avg_value), 32'd1000);
    check("t2b_fault_sticky", 32'(fault), 32'd1);
    pulse_clear();
    check("t2_cleared", 32'(fault), 32'd0);
    push4(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    fault_clear = 1'b1;
    wait_avg("t2c");
    check("t2c_set_wins", 32'(fault), 32'd1);
    fault_clear = 1'b0;
    @(negedge clk);
    check("t2c_fault_hold", 32'(fault), 32'd1);

    // Truncation and low threshold.
    pulse_clear();
    check("t3_cleared", 32'(fault), 32'd0);
    thr_high = 12'd4095;
    thr_low  = 12'd2;
    push4(12'd1, 12'd1, 12'd1, 12'd2);
    wait_avg("t3");
    check("t3_avg_trunc", 32'(avg_value), 32'd1);
    check("t3_fault_low", 32'(fault), 32'd1);

    // Recalibration requested mid-conversion, with a repeat that must be absorbed.
    r0 = read_cnt;
    adc_q.push_back(12'($urandom));
    adc_q.push_back(12'($urandom));
    for (int i = 0; i < 4; i++) begin
      v[i] = 12'($urandom);
      adc_q.push_back(v[i]);
    end
    exp_avg = (int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3])) >> AL;
    wait_reads(r0 + 2, "t4_second");
    for (int i = 0; i < 20 && adc_read; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    recal_req = 1'b1; @(negedge clk); recal_req = 1'b0;
    repeat (2) @(negedge clk);
    recal_req = 1'b1; @(negedge clk); recal_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (recal_cnt >= 1);
    end
    check("t4_recal_seen", 32'(got), 32'd1);
    check("t4_recal_at_boundary", 32'(last_recal - last_read), 32'(SP));
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (adc_recalibrate) hi++;
      @(negedge clk);
    end
    check("t4_recal_hold", 32'(hi), 32'(RH));
    check("t4_no_read_in_recal", 32'(read_cnt), 32'(r0 + 2));
    wait_reads(r0 + 3, "t4_resume");
    check("t4_resume_gap", 32'(last_read - last_recal), 32'(RH + CAL + 1));
    wait_avg("t4");
    check("t4_avg_fresh", 32'(avg_value), 32'(exp_avg));
    check("t4_single_recal", 32'(recal_cnt), 32'd1);

    // Enable dropped after two samples: partial block discarded.
    r0 = read_cnt;
    adc_q.push_back(12'($urandom_range(2048, 4095)));
    adc_q.push_back(12'($urandom_range(2048, 4095)));
    wait_reads(r0 + 2, "t5_second");
    enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = !busy;
    end
    t_idle = cyc;
    check("t5_idle_seen", 32'(got), 32'd1);
    check("t5_idle_after_gap", 32'(t_idle - last_read), 32'(SP));
    repeat (50) @(negedge clk);
    check("t5_no_reads_idle", 32'(read_cnt), 32'(r0 + 2));
    push4(12'd50, 12'd50, 12'd50, 12'd50);
    enable = 1'b1;
    wait_avg("t5");
    check("t5_avg", 32'(avg_value), 32'd50);

    // Randomized blocks against the reference average/fault model.
    pulse_clear();
    exp_fault = 1'b0;
    check("rnd_start_fault", 32'(fault), 32'd0);
    for (int blk = 0; blk < 6; blk++) begin
      if (blk % 2 == 1) begin
        pulse_clear();
        exp_fault = 1'b0;
      end
      tl = int'($urandom_range(1200, 2400));
      th = tl + int'($urandom_range(0, 800));
      thr_low  = 12'(tl);
      thr_high = 12'(th);
      for (int i = 0; i < 4; i++) begin
        v[i] = 12'($urandom);
        adc_q.push_back(v[i]);
      end
      exp_avg = (int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3])) / 4;
      if (exp_avg > th || exp_avg < tl) exp_fault = 1'b1;
      wait_avg($sformatf("rnd%0d", blk));
      check($sformatf("rnd%0d_avg", blk), 32'(avg_value), 32'(exp_avg));
      check($sformatf("rnd%0d_fault", blk), 32'(fault), 32'(exp_fault));
    end

    // Reset during a conversion.
    r0 = read_cnt;
    wait_reads(r0 + 1, "rst_read");
    for (int i = 0; i < 20 && adc_read; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rst_busy_before", 32'(busy), 32'd1);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_zero("rst_conv");
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_read", 32'(read_cnt), 32'(r0 + 1));
    check("rst_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_reads(r0 + 2, "rst_reenable");
    check("rst_reenable_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
